// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Purpose : Shared constants for the BCD calculator core: keypad codes for the
//           operator/control keys, FSM state encodings, operator encoding and a
//           small BCD helper.
// Ports   : none (package).
// Config  : none here; the subtract feature is selected in bcd_calc_core by
//           the CALC_SUB_EN macro.
// -----------------------------------------------------------------------------
package calc_pkg;

  // Keypad codes. Codes 0-9 are digits; C and D carry no meaning.
  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_EQ  = 4'hE;
  localparam logic [3:0] KEY_CLR = 4'hF;

  // FSM state codes, also driven out on the debug/LED state port.
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ENTER_A = 3'd1;
  localparam logic [2:0] S_ENTER_B = 3'd2;
  localparam logic [2:0] S_CALC    = 3'd3;
  localparam logic [2:0] S_CPL     = 3'd4;
  localparam logic [2:0] S_SHOW    = 3'd5;

  // Latched operator.
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Nines complement of one BCD digit.
  function automatic logic [3:0] nines(input logic [3:0] d);
    return 4'd9 - d;
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// -----------------------------------------------------------------------------
// bcd_digit_add
// Purpose : Combinational single-digit BCD adder: a + b + carry-in gives one
//           BCD digit and a carry-out. Both inputs must be valid BCD (0-9).
// Ports   : a_i    [3:0] BCD digit
//           b_i    [3:0] BCD digit
//           cin_i        carry in
//           sum_o  [3:0] BCD sum digit
//           cout_o       carry out (decimal)
// -----------------------------------------------------------------------------
module bcd_digit_add (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o
);

  logic [4:0] bin_sum;
  logic [4:0] adj_sum;

  always_comb begin
    bin_sum = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, cin_i};
    // Binary sums above 9 wrap into the next decade: adding 6 skips the six
    // unused 4-bit codes, leaving the decimal digit in the low nibble.
    adj_sum = bin_sum + 5'd6;
    if (bin_sum > 5'd9) begin
      sum_o  = adj_sum[3:0];
      cout_o = 1'b1;
    end else begin
      sum_o  = bin_sum[3:0];
      cout_o = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_calc_core.sv
// -----------------------------------------------------------------------------
// bcd_calc_core
// Purpose : Multi-digit BCD calculator core. Collects two DIGITS-wide BCD
//           operands from keypad strokes, then adds (or subtracts) them one
//           digit per cycle through a single shared bcd_digit_add. A negative
//           subtraction result is turned into a magnitude by a second
//           digit-serial tens-complement pass.
// Ports   : clk              system clock
//           rst_n            asynchronous active-low reset
//           key      [3:0]   key code, meaningful only while key_valid=1
//           key_valid        one-cycle strobe per keypress
//           disp     [4D-1:0] display buffer, digit 0 = [3:0] = LSD
//           neg              result negative (disp holds magnitude)
//           ovf              result overflowed DIGITS digits
//           busy             digit-serial calculation in progress
//           state    [2:0]   FSM state code (calc_pkg S_* values)
// Params  : DIGITS  operand/result width in BCD digits, 1..8
// Config  : CALC_SUB_EN defined   -> B key subtracts, CPL pass and neg active.
//           CALC_SUB_EN undefined -> B key ignored, neg tied low.
// Strobe  : key is sampled on every rising clk edge where key_valid=1; each
//           such edge is one keypress. There is no back-pressure: keys other
//           than F that arrive while busy=1 are dropped.
// -----------------------------------------------------------------------------
module bcd_calc_core
  import calc_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            key,
  input  logic                  key_valid,
  output logic [DIGITS*4-1:0]   disp,
  output logic                  neg,
  output logic                  ovf,
  output logic                  busy,
  output logic [2:0]            state
);

  localparam int         W    = DIGITS * 4;
  localparam logic [3:0] LAST = 4'(DIGITS - 1);

`ifdef CALC_SUB_EN
  localparam logic SUB_EN = 1'b1;
`else
  localparam logic SUB_EN = 1'b0;
`endif

  // Operand entry: shift a new LSD in, dropping the old top digit slot.
  function automatic logic [W-1:0] shift_in(input logic [W-1:0] v,
                                            input logic [3:0]   d);
    logic [W+3:0] t;
    t = {v, d};
    return t[W-1:0];
  endfunction

  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic [W-1:0] r_q, r_d;
  logic         op_q, op_d;
  logic         neg_q, neg_d;
  logic         ovf_q, ovf_d;
  logic         carry_q, carry_d;
  logic [2:0]   state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;

  // Key decode
  logic key_digit, key_op, key_eq, key_clr;
  logic key_opcode;

  always_comb begin
    key_digit  = key_valid && (key <= 4'd9);
    key_op     = key_valid && ((key == KEY_ADD) || (SUB_EN && (key == KEY_SUB)));
    key_eq     = key_valid && (key == KEY_EQ);
    key_clr    = key_valid && (key == KEY_CLR);
    key_opcode = (key == KEY_SUB) ? OP_SUB : OP_ADD;
  end

  // Shared digit adder. During CALC it sees A[cnt] and B[cnt] (or nines(B)
  // for subtraction); during CPL it sees nines(R[cnt]) + 0 with the carry
  // seeded to 1, which forms the tens complement of R.
  logic [3:0] a_dig, b_dig, r_dig;
  logic [3:0] add_x, add_y, add_sum;
  logic       add_cout;

  always_comb begin
    a_dig = a_q[cnt_q*4 +: 4];
    b_dig = b_q[cnt_q*4 +: 4];
    r_dig = r_q[cnt_q*4 +: 4];
    if (state_q == S_CPL) begin
      add_x = nines(r_dig);
      add_y = 4'd0;
    end else begin
      add_x = a_dig;
      add_y = (op_q == OP_SUB) ? nines(b_dig) : b_dig;
    end
  end

  bcd_digit_add u_add (
    .a_i    (add_x),
    .b_i    (add_y),
    .cin_i  (carry_q),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  // Next-state logic
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    op_d    = op_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
    carry_d = carry_q;
    state_d = state_q;
    cnt_d   = cnt_q;

    if (key_clr) begin
      // Clear wins in every state, including mid-calculation.
      a_d     = '0;
      b_d     = '0;
      r_d     = '0;
      op_d    = OP_ADD;
      neg_d   = 1'b0;
      ovf_d   = 1'b0;
      carry_d = 1'b0;
      cnt_d   = 4'd0;
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (key_digit) begin
            a_d     = W'(key);
            state_d = S_ENTER_A;
          end else if (key_op) begin
            a_d     = '0;
            b_d     = '0;
            op_d    = key_opcode;
            state_d = S_ENTER_B;
          end
        end

        S_ENTER_A: begin
          if (key_digit) begin
            // A full operand (nonzero top digit) drops further digits;
            // leading zeros do not fill it.
            if (a_q[W-1 -: 4] == 4'd0) a_d = shift_in(a_q, key);
          end else if (key_op) begin
            b_d     = '0;
            op_d    = key_opcode;
            state_d = S_ENTER_B;
          end
        end

        S_ENTER_B: begin
          if (key_digit) begin
            if (b_q[W-1 -: 4] == 4'd0) b_d = shift_in(b_q, key);
          end else if (key_op) begin
            op_d = key_opcode;
          end else if (key_eq) begin
            // Subtraction is A + nines(B) + 1.
            carry_d = (op_q == OP_SUB);
            cnt_d   = 4'd0;
            neg_d   = 1'b0;
            ovf_d   = 1'b0;
            state_d = S_CALC;
          end
        end

        S_CALC: begin
          r_d[cnt_q*4 +: 4] = add_sum;
          carry_d           = add_cout;
          cnt_d             = cnt_q + 4'd1;
          if (cnt_q == LAST) begin
            cnt_d = 4'd0;
            if (op_q == OP_ADD) begin
              ovf_d   = add_cout;
              state_d = S_SHOW;
            end else if (add_cout) begin
              // Carry out of A + nines(B) + 1 means A >= B.
              state_d = S_SHOW;
            end else begin
              // No carry: R holds the tens complement of |A - B|.
              carry_d = 1'b1;
              state_d = S_CPL;
            end
          end
        end

        S_CPL: begin
          r_d[cnt_q*4 +: 4] = add_sum;
          carry_d           = add_cout;
          cnt_d             = cnt_q + 4'd1;
          if (cnt_q == LAST) begin
            cnt_d   = 4'd0;
            carry_d = 1'b0;
            neg_d   = 1'b1;
            state_d = S_SHOW;
          end
        end

        S_SHOW: begin
          if (key_digit) begin
            neg_d   = 1'b0;
            ovf_d   = 1'b0;
            a_d     = W'(key);
            state_d = S_ENTER_A;
          end else if (key_op && !neg_q && !ovf_q) begin
            // Chain: the shown result becomes the next left operand.
            a_d     = r_q;
            b_d     = '0;
            op_d    = key_opcode;
            state_d = S_ENTER_B;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      op_q    <= OP_ADD;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= 4'd0;
      state_q <= S_IDLE;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  // Display source follows the operand being edited; B stays on screen while
  // the calculation runs so R can be built in place.
  always_comb begin
    case (state_q)
      S_IDLE, S_ENTER_A:         disp = a_q;
      S_ENTER_B, S_CALC, S_CPL:  disp = b_q;
      S_SHOW:                    disp = r_q;
      default:                   disp = a_q;
    endcase
  end

  assign busy  = (state_q == S_CALC) || (state_q == S_CPL);
  assign ovf   = ovf_q;
  assign state = state_q;

`ifdef CALC_SUB_EN
  assign neg = neg_q;
`else
  assign neg = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_calc_core.sv
// -----------------------------------------------------------------------------
// tb_bcd_calc_core
// Bench for bcd_calc_core: a DIGITS=4 instance for most scenarios and a
// DIGITS=1 instance for the single-digit overflow case. Expected snapshots
// {state, ovf, neg, busy, disp} are pushed when keys are driven and popped
// when the DUT output is sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_bcd_calc_core;
  import calc_pkg::*;

  // Clock / reset
  logic clk;
  logic rst_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // DUT, DIGITS=4
  logic [3:0]  key;
  logic        key_valid;
  logic [15:0] disp;
  logic        neg, ovf, busy;
  logic [2:0]  state;

  bcd_calc_core #(.DIGITS(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key       (key),
    .key_valid (key_valid),
    .disp      (disp),
    .neg       (neg),
    .ovf       (ovf),
    .busy      (busy),
    .state     (state)
  );

  // DUT, DIGITS=1
  logic [3:0] key1;
  logic       key_valid1;
  logic [3:0] disp1;
  logic       neg1, ovf1, busy1;
  logic [2:0] state1;

  bcd_calc_core #(.DIGITS(1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .key       (key1),
    .key_valid (key_valid1),
    .disp      (disp1),
    .neg       (neg1),
    .ovf       (ovf1),
    .busy      (busy1),
    .state     (state1)
  );

  // Scoreboard
  localparam int SW = 22;
  logic [SW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [SW-1:0] pack(input logic [2:0] st, input logic o,
                                         input logic n, input logic b,
                                         input logic [15:0] d);
    return {st, o, n, b, d};
  endfunction

  task automatic exp_push(input logic [2:0] st, input logic o, input logic n,
                          input logic b, input logic [15:0] d);
    exp_q.push_back(pack(st, o, n, b, d));
  endtask

  task automatic sb_check(input string tag, input logic [SW-1:0] obs);
    logic [SW-1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_noexp"}, 32'(obs), 32'hFFFF_FFFF);
    end else begin
      e = exp_q.pop_front();
      check(tag, 32'(obs), 32'(e));
    end
  endtask

  function automatic logic [SW-1:0] snap();
    return pack(state, ovf, neg, busy, disp);
  endfunction

  function automatic logic [SW-1:0] snap1();
    return pack(state1, ovf1, neg1, busy1, {12'h000, disp1});
  endfunction

  // Reference: integer to 4-digit BCD.
  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Driver tasks (called on a falling edge, return on the next falling edge)
  task automatic press(input logic [3:0] k);
    key       = k;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic press1(input logic [3:0] k);
    key1       = k;
    key_valid1 = 1'b1;
    @(negedge clk);
    key_valid1 = 1'b0;
  endtask

  task automatic enter_num(input int v);
    int d[8];
    int n;
    int x;
    n = 0;
    x = v;
    if (x == 0) begin
      press(4'd0);
    end else begin
      while (x > 0 && n < 8) begin
        d[n] = x % 10;
        x = x / 10;
        n++;
      end
      for (int i = n - 1; i >= 0; i--) press(4'(d[i]));
    end
  endtask

  task automatic wait_not_busy(output int n);
    n = 0;
    while (busy && n < 64) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic run_calc(input int a, input int b, input bit sub);
    int r, ebusy, n;
    bit eneg, eovf;
    press(KEY_CLR);
    enter_num(a);
    press(sub ? KEY_SUB : KEY_ADD);
    enter_num(b);
    if (!sub) begin
      r     = a + b;
      eovf  = (r > 9999);
      r     = r % 10000;
      eneg  = 1'b0;
      ebusy = 4;
    end else begin
      r     = a - b;
      eneg  = (r < 0);
      if (eneg) r = -r;
      eovf  = 1'b0;
      ebusy = eneg ? 8 : 4;
    end
    exp_push(S_SHOW, eovf, eneg, 1'b0, to_bcd(r));
    press(KEY_EQ);
    wait_not_busy(n);
    check($sformatf("busy_cycles_%0d_%0d", a, b), 32'(n), 32'(ebusy));
    sb_check($sformatf("calc_%0d_%0d", a, b), snap());
  endtask

  // Stimulus
  initial begin
    int n;
    rst_n      = 1'b0;
    key        = 4'd0;
    key_valid  = 1'b0;
    key1       = 4'd0;
    key_valid1 = 1'b0;

    #12;
    exp_push(S_IDLE, 1'b0, 1'b0, 1'b0, 16'h0000);
    sb_check("reset_state", snap());
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic add
    run_calc(123, 45, 1'b0);

    // Overflow, op ignored after overflow, digit restarts
    run_calc(9999, 1, 1'b0);
    exp_push(S_SHOW, 1'b1, 1'b0, 1'b0, 16'h0000);
    press(KEY_ADD);
    sb_check("ovf_op_ignored", snap());
    exp_push(S_ENTER_A, 1'b0, 1'b0, 1'b0, 16'h0007);
    press(4'd7);
    sb_check("ovf_digit_restart", snap());

`ifdef CALC_SUB_EN
    run_calc(45, 123, 1'b1);
    exp_push(S_SHOW, 1'b0, 1'b1, 1'b0, 16'h0078);
    press(KEY_ADD);
    sb_check("neg_op_ignored", snap());
    run_calc(500, 123, 1'b1);
    run_calc(77, 77, 1'b1);
    for (int i = 0; i < 4; i++) run_calc($urandom_range(0, 9999), $urandom_range(0, 9999), 1'b1);
`else
    press(KEY_CLR);
    press(4'd4);
    press(4'd5);
    exp_push(S_ENTER_A, 1'b0, 1'b0, 1'b0, 16'h0045);
    press(KEY_SUB);
    sb_check("sub_key_ignored", snap());
    exp_push(S_ENTER_A, 1'b0, 1'b0, 1'b0, 16'h0451);
    press(4'd1);
    sb_check("sub_key_ignored_digit", snap());
`endif

    // Digit entry: fifth digit dropped, leading zeros not counted
    press(KEY_CLR);
    enter_num(1234);
    exp_push(S_ENTER_A, 1'b0, 1'b0, 1'b0, 16'h1234);
    press(4'd5);
    sb_check("entry_full", snap());
    press(KEY_CLR);
    press(4'd0);
    press(4'd0);
    exp_push(S_ENTER_A, 1'b0, 1'b0, 1'b0, 16'h0007);
    press(4'd7);
    sb_check("entry_lead_zero", snap());
    exp_push(S_ENTER_A, 1'b0, 1'b0, 1'b0, 16'h0007);
    press(4'hC);
    press(4'hD);
    sb_check("keys_cd_ignored", snap());

    // Chain 1 A 2 E A 3 E, with a digit pressed while busy
    run_calc(1, 2, 1'b0);
    exp_push(S_ENTER_B, 1'b0, 1'b0, 1'b0, 16'h0000);
    press(KEY_ADD);
    sb_check("chain_op", snap());
    press(4'd3);
    press(KEY_EQ);
    press(4'd9);
    wait_not_busy(n);
    exp_push(S_SHOW, 1'b0, 1'b0, 1'b0, 16'h0006);
    sb_check("chain_result", snap());

    // Random additions
    for (int i = 0; i < 6; i++) run_calc($urandom_range(0, 9999), $urandom_range(0, 9999), 1'b0);

    // Clear during the second busy cycle
    press(KEY_CLR);
    press(4'd8);
    press(KEY_ADD);
    press(4'd6);
    press(KEY_EQ);
    @(negedge clk);
    exp_push(S_IDLE, 1'b0, 1'b0, 1'b0, 16'h0000);
    press(KEY_CLR);
    sb_check("clear_mid_calc", snap());

    // Asynchronous reset in the middle of CALC
    press(4'd9);
    press(KEY_ADD);
    press(4'd9);
    press(KEY_EQ);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_push(S_IDLE, 1'b0, 1'b0, 1'b0, 16'h0000);
    sb_check("async_reset_mid_calc", snap());
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // DIGITS=1: 5 + 7 -> 2 with overflow
    press1(4'd5);
    press1(KEY_ADD);
    press1(4'd7);
    exp_push(S_SHOW, 1'b1, 1'b0, 1'b0, 16'h0002);
    press1(KEY_EQ);
    n = 0;
    while (busy1 && n < 64) begin
      n++;
      @(negedge clk);
    end
    check("d1_busy_cycles", 32'(n), 32'd1);
    sb_check("d1_calc", snap1());

    check("sb_leftover", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
